mem_access_stage: RTL and testbench

Combinational-datapath MEM stage with a sequential LM/SM micro-sequencer, between the EX/MEM register and the MEM/WB pipeline register.
- Performs single LW/SW accesses to data memory.
- Expands LM/SM (8-bit register mask) into one memory access per set bit.
- Emits one writeback record per cycle toward MEM/WB.
- Freezes upstream stages via mem_stall while a multi-cycle operation or a memory wait is in progress.

---
 rtl/mem_access_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: combinational LW/SW datapath plus an LM/SM micro-sequencer that
// expands a register mask into one data-memory transfer per set bit.
module mem_access_stage #(
  parameter logic [15:0] ADDR_STEP = 16'd2,
  parameter logic [1:0]  WB_MEM    = 2'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  input  logic        lm_in,
  input  logic        sm_in,
  input  logic [7:0]  mask_in,
  input  logic        rf_we_in,
  input  logic [2:0]  rf_waddr_in,
  input  logic [1:0]  wb_sel_in,
  input  logic [15:0] alu_res_in,
  input  logic [15:0] store_data_in,
  input  logic [15:0] pc2_in,
  input  logic [15:0] imm_eff_in,
  output logic [2:0]  sm_raddr,
  input  logic [15:0] sm_rdata,
  output logic [15:0] dmem_addr,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        rf_we_out,
  output logic [2:0]  rf_waddr_out,
  output logic [1:0]  wb_sel_out,
  output logic [15:0] alu_res_out,
  output logic [15:0] mem_rdata_out,
  output logic [15:0] pc2_out,
  output logic [15:0] imm_eff_out
);

  typedef enum logic {IDLE, MULTI} state_t;

  state_t      state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic [15:0] addr_q, addr_d;
  logic        lm_q, lm_d;
  logic        sm_q, sm_d;
  logic [15:0] pc2_q, pc2_d;
  logic [15:0] imm_q, imm_d;

  logic        in_multi, multi_act, single_act, is_lm, is_sm, found;
  logic [7:0]  cur_mask, rest;
  logic [15:0] cur_addr;
  logic [2:0]  idx;

  always_comb begin
    in_multi = (state_q == MULTI);
    cur_mask = in_multi ? mask_q : mask_in;
    cur_addr = in_multi ? addr_q : alu_res_in;

    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (cur_mask[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    rest = cur_mask & ~(8'd1 << idx);

    // LM wins if upstream ever raises both lm_in and sm_in, so only one strobe fires
    is_lm      = in_multi ? lm_q : lm_in;
    is_sm      = in_multi ? sm_q : (sm_in & ~lm_in);
    multi_act  = in_multi | (valid_in & (lm_in | sm_in) & (|mask_in));
    single_act = ~in_multi & valid_in & ~lm_in & ~sm_in;

    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    lm_d    = lm_q;
    sm_d    = sm_q;
    pc2_d   = pc2_q;
    imm_d   = imm_q;

    sm_raddr      = '0;
    dmem_addr     = '0;
    dmem_re       = 1'b0;
    dmem_we       = 1'b0;
    dmem_wdata    = '0;
    mem_stall     = 1'b0;
    rf_we_out     = 1'b0;
    rf_waddr_out  = '0;
    wb_sel_out    = '0;
    alu_res_out   = '0;
    mem_rdata_out = '0;
    pc2_out       = '0;
    imm_eff_out   = '0;

    if (rst) begin
      // outputs stay at bubble; the flops clear on the edge
    end else if (multi_act) begin
      dmem_addr  = cur_addr;
      sm_raddr   = idx;
      dmem_re    = is_lm;
      dmem_we    = is_sm;
      dmem_wdata = is_sm ? sm_rdata : '0;
      mem_stall  = ~dmem_ready | (|rest);
      if (dmem_ready) begin
        rf_we_out     = is_lm;
        rf_waddr_out  = idx;
        wb_sel_out    = WB_MEM;
        alu_res_out   = cur_addr;
        mem_rdata_out = dmem_rdata;
        pc2_out       = in_multi ? pc2_q : pc2_in;
        imm_eff_out   = in_multi ? imm_q : imm_eff_in;
        if (|rest) begin
          state_d = MULTI;
          mask_d  = rest;
          addr_d  = cur_addr + ADDR_STEP;
          if (!in_multi) begin
            lm_d  = is_lm;
            sm_d  = is_sm;
            pc2_d = pc2_in;
            imm_d = imm_eff_in;
          end
        end else begin
          state_d = IDLE;
        end
      end
    end else if (single_act) begin
      dmem_addr  = alu_res_in;
      dmem_re    = mem_rd_in;
      dmem_we    = mem_wr_in & ~mem_rd_in;
      dmem_wdata = store_data_in;
      if ((mem_rd_in | mem_wr_in) & ~dmem_ready) begin
        mem_stall = 1'b1;
      end else begin
        rf_we_out     = rf_we_in;
        rf_waddr_out  = rf_waddr_in;
        wb_sel_out    = wb_sel_in;
        alu_res_out   = alu_res_in;
        mem_rdata_out = dmem_rdata;
        pc2_out       = pc2_in;
        imm_eff_out   = imm_eff_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      lm_q    <= 1'b0;
      sm_q    <= 1'b0;
      pc2_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      lm_q    <= lm_d;
      sm_q    <= sm_d;
      pc2_q   <= pc2_d;
      imm_q   <= imm_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand sequences for LM/SM
// corner cases, and randomized transactions against a transfer-list model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_rd_in, mem_wr_in, lm_in, sm_in;
  logic [7:0]  mask_in;
  logic        rf_we_in;
  logic [2:0]  rf_waddr_in;
  logic [1:0]  wb_sel_in;
  logic [15:0] alu_res_in, store_data_in, pc2_in, imm_eff_in;
  logic [2:0]  sm_raddr;
  logic [15:0] sm_rdata;
  logic [15:0] dmem_addr;
  logic        dmem_re, dmem_we;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        mem_stall, rf_we_out;
  logic [2:0]  rf_waddr_out;
  logic [1:0]  wb_sel_out;
  logic [15:0] alu_res_out, mem_rdata_out, pc2_out, imm_eff_out;

  logic [15:0] rf [8];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign sm_rdata = rf[sm_raddr];

  mem_access_stage #(.ADDR_STEP(16'd2), .WB_MEM(2'd1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_rd_in(mem_rd_in),
    .mem_wr_in(mem_wr_in), .lm_in(lm_in), .sm_in(sm_in), .mask_in(mask_in),
    .rf_we_in(rf_we_in), .rf_waddr_in(rf_waddr_in), .wb_sel_in(wb_sel_in),
    .alu_res_in(alu_res_in), .store_data_in(store_data_in), .pc2_in(pc2_in),
    .imm_eff_in(imm_eff_in), .sm_raddr(sm_raddr), .sm_rdata(sm_rdata),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_stall(mem_stall), .rf_we_out(rf_we_out), .rf_waddr_out(rf_waddr_out),
    .wb_sel_out(wb_sel_out), .alu_res_out(alu_res_out),
    .mem_rdata_out(mem_rdata_out), .pc2_out(pc2_out), .imm_eff_out(imm_eff_out)
  );

  typedef struct {
    logic        valid, rd, wr, lm, sm;
    logic [7:0]  mask;
    logic        rfwe;
    logic [2:0]  waddr;
    logic [15:0] alu, sdata, rdata;
    logic        ready;
    logic        e_re, e_we, e_stall, e_rfwe;
    logic [2:0]  e_waddr, e_raddr;
    logic [15:0] e_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    valid_in = 0; mem_rd_in = 0; mem_wr_in = 0; lm_in = 0; sm_in = 0;
    mask_in = '0; rf_we_in = 0; rf_waddr_in = '0; wb_sel_in = '0;
    alu_res_in = '0; store_data_in = '0; pc2_in = '0; imm_eff_in = '0;
    dmem_rdata = '0; dmem_ready = 1'b1;
  endtask

  // check one cycle at the falling edge, then step to just after the next rising edge
  task automatic hcyc(input string tag, input logic multi, input logic re, input logic we,
                      input logic stall, input logic rfwe, input logic [15:0] addr,
                      input logic [2:0] raddr, input logic [2:0] waddr,
                      input logic [15:0] rdata, input logic [15:0] wdata);
    @(negedge clk);
    chk({tag, ".re"}, 16'(dmem_re), 16'(re));
    chk({tag, ".we"}, 16'(dmem_we), 16'(we));
    chk({tag, ".stall"}, 16'(mem_stall), 16'(stall));
    chk({tag, ".rf_we"}, 16'(rf_we_out), 16'(rfwe));
    if (re || we) chk({tag, ".addr"}, dmem_addr, addr);
    if (we) chk({tag, ".wdata"}, dmem_wdata, wdata);
    if (multi) chk({tag, ".raddr"}, 16'(sm_raddr), 16'(raddr));
    if (rfwe) begin
      chk({tag, ".waddr"}, 16'(rf_waddr_out), 16'(waddr));
      chk({tag, ".rdata"}, mem_rdata_out, rdata);
    end
    @(posedge clk); #1;
  endtask

  vec_t tv [10];

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'hA000 + 16'(i * 16'h0111);
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    hcyc("reset0", 0, 0, 0, 0, 0, '0, '0, '0, '0, '0);
    rst = 1'b0;

    //        valid rd wr lm sm mask  rfwe wa  alu       sdata     rdata     rdy  re we st rfwe ewa era erdata
    tv[0] = '{0, 0, 0, 0, 0, 8'h00, 1, 5, 16'h1234, 16'h5678, 16'h9999, 1, 0, 0, 0, 0, 0, 0, 16'h0000};
    tv[1] = '{1, 0, 0, 0, 0, 8'h00, 1, 5, 16'h1234, 16'h5678, 16'h9999, 1, 0, 0, 0, 1, 5, 0, 16'h9999};
    tv[2] = '{1, 1, 0, 0, 0, 8'h00, 1, 2, 16'h0040, 16'h0000, 16'hBEEF, 1, 1, 0, 0, 1, 2, 0, 16'hBEEF};
    tv[3] = '{1, 1, 0, 0, 0, 8'h00, 1, 2, 16'h0040, 16'h0000, 16'hBEEF, 0, 1, 0, 1, 0, 0, 0, 16'h0000};
    tv[4] = '{1, 0, 1, 0, 0, 8'h00, 0, 0, 16'h0080, 16'hCAFE, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 16'h0000};
    tv[5] = '{1, 0, 1, 0, 0, 8'h00, 0, 0, 16'h0080, 16'hCAFE, 16'h0000, 0, 0, 1, 1, 0, 0, 0, 16'h0000};
    tv[6] = '{1, 0, 0, 1, 0, 8'h00, 0, 0, 16'h0100, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 16'h0000};
    tv[7] = '{1, 0, 0, 0, 1, 8'h00, 0, 0, 16'h0100, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 16'h0000};
    tv[8] = '{1, 0, 0, 1, 0, 8'h10, 0, 0, 16'h0200, 16'h0000, 16'h4321, 1, 1, 0, 0, 1, 4, 4, 16'h4321};
    tv[9] = '{1, 0, 0, 1, 0, 8'h10, 0, 0, 16'h0200, 16'h0000, 16'h4321, 0, 1, 0, 1, 0, 0, 4, 16'h0000};

    for (int i = 0; i < 10; i++) begin
      valid_in = tv[i].valid; mem_rd_in = tv[i].rd; mem_wr_in = tv[i].wr;
      lm_in = tv[i].lm; sm_in = tv[i].sm; mask_in = tv[i].mask;
      rf_we_in = tv[i].rfwe; rf_waddr_in = tv[i].waddr; alu_res_in = tv[i].alu;
      store_data_in = tv[i].sdata; dmem_rdata = tv[i].rdata; dmem_ready = tv[i].ready;
      hcyc($sformatf("vec%0d", i), (tv[i].lm || tv[i].sm) && tv[i].mask != 0,
           tv[i].e_re, tv[i].e_we, tv[i].e_stall, tv[i].e_rfwe, tv[i].alu,
           tv[i].e_raddr, tv[i].e_waddr, tv[i].e_rdata, tv[i].sdata);
    end
    clear_inputs();

    // reset while an LM is mid-sequence
    valid_in = 1; lm_in = 1; mask_in = 8'hFF; alu_res_in = 16'h0500;
    dmem_rdata = 16'h1111;
    hcyc("rstlm.c1", 1, 1, 0, 1, 1, 16'h0500, 0, 0, 16'h1111, '0);
    hcyc("rstlm.c2", 1, 1, 0, 1, 1, 16'h0502, 1, 1, 16'h1111, '0);
    rst = 1'b1;
    hcyc("rstlm.r1", 0, 0, 0, 0, 0, '0, '0, '0, '0, '0);
    hcyc("rstlm.r2", 0, 0, 0, 0, 0, '0, '0, '0, '0, '0);
    rst = 1'b0;
    clear_inputs();
    hcyc("rstlm.bubble", 0, 0, 0, 0, 0, '0, '0, '0, '0, '0);

    // LW with two wait cycles
    valid_in = 1; mem_rd_in = 1; rf_we_in = 1; rf_waddr_in = 3; wb_sel_in = 2'd1;
    alu_res_in = 16'h0040; dmem_ready = 0;
    hcyc("lw.w1", 0, 1, 0, 1, 0, 16'h0040, 0, 0, 0, 0);
    hcyc("lw.w2", 0, 1, 0, 1, 0, 16'h0040, 0, 0, 0, 0);
    dmem_ready = 1; dmem_rdata = 16'hBEEF;
    hcyc("lw.done", 0, 1, 0, 0, 1, 16'h0040, 0, 3, 16'hBEEF, 0);
    clear_inputs();

    // LM mask A5 from 0100
    valid_in = 1; lm_in = 1; mask_in = 8'b1010_0101; alu_res_in = 16'h0100;
    dmem_rdata = 16'hD000;
    hcyc("lm.c1", 1, 1, 0, 1, 1, 16'h0100, 0, 0, 16'hD000, 0);
    dmem_rdata = 16'hD002;
    hcyc("lm.c2", 1, 1, 0, 1, 1, 16'h0102, 2, 2, 16'hD002, 0);
    dmem_rdata = 16'hD005;
    hcyc("lm.c3", 1, 1, 0, 1, 1, 16'h0104, 5, 5, 16'hD005, 0);
    dmem_rdata = 16'hD007;
    hcyc("lm.c4", 1, 1, 0, 0, 1, 16'h0106, 7, 7, 16'hD007, 0);
    clear_inputs();
    hcyc("lm.after", 0, 0, 0, 0, 0, '0, '0, '0, '0, '0);

    // SM mask 81 wrapping through FFFE
    valid_in = 1; sm_in = 1; mask_in = 8'h81; alu_res_in = 16'hFFFE;
    hcyc("smwrap.c1", 1, 0, 1, 1, 0, 16'hFFFE, 0, 0, 0, rf[0]);
    hcyc("smwrap.c2", 1, 0, 1, 0, 0, 16'h0000, 7, 0, 0, rf[7]);
    clear_inputs();

    // LM with empty mask is a one-cycle no-op
    valid_in = 1; lm_in = 1; mask_in = 8'h00; alu_res_in = 16'h0300;
    hcyc("lm0", 0, 0, 0, 0, 0, '0, '0, '0, '0, '0);
    clear_inputs();

    // SM mask 0F with one wait state on the third transfer
    valid_in = 1; sm_in = 1; mask_in = 8'h0F; alu_res_in = 16'h0300;
    hcyc("smw.c1", 1, 0, 1, 1, 0, 16'h0300, 0, 0, 0, rf[0]);
    hcyc("smw.c2", 1, 0, 1, 1, 0, 16'h0302, 1, 0, 0, rf[1]);
    dmem_ready = 0;
    hcyc("smw.c3", 1, 0, 1, 1, 0, 16'h0304, 2, 0, 0, rf[2]);
    dmem_ready = 1;
    hcyc("smw.c4", 1, 0, 1, 1, 0, 16'h0304, 2, 0, 0, rf[2]);
    hcyc("smw.c5", 1, 0, 1, 0, 0, 16'h0306, 3, 0, 0, rf[3]);
    clear_inputs();
    hcyc("smw.after", 0, 0, 0, 0, 0, '0, '0, '0, '0, '0);

    // randomized transactions against a transfer-list model
    for (int t = 0; t < 150; t++) begin
      int op;
      op = int'($urandom_range(0, 5));
      for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
      clear_inputs();
      rf_we_in = 1'($urandom); rf_waddr_in = 3'($urandom); wb_sel_in = 2'($urandom);
      alu_res_in = 16'($urandom); store_data_in = 16'($urandom);
      pc2_in = 16'($urandom); imm_eff_in = 16'($urandom);
      if (op <= 3) begin
        logic mem;
        bit done;
        valid_in = (op != 0); mem_rd_in = (op == 2); mem_wr_in = (op == 3);
        mem = mem_rd_in | mem_wr_in;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
          logic pend;
          dmem_ready = (c >= 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
          dmem_rdata = 16'($urandom);
          pend = valid_in && mem && !dmem_ready;
          @(negedge clk);
          chk("rnd.s.re", 16'(dmem_re), 16'(valid_in && mem_rd_in));
          chk("rnd.s.we", 16'(dmem_we), 16'(valid_in && mem_wr_in));
          chk("rnd.s.stall", 16'(mem_stall), 16'(pend));
          chk("rnd.s.rf_we", 16'(rf_we_out), 16'(valid_in && !pend && rf_we_in));
          if (valid_in && mem) chk("rnd.s.addr", dmem_addr, alu_res_in);
          if (valid_in && mem_wr_in) chk("rnd.s.wdata", dmem_wdata, store_data_in);
          if (valid_in && !pend) begin
            chk("rnd.s.waddr", 16'(rf_waddr_out), 16'(rf_waddr_in));
            chk("rnd.s.wb_sel", 16'(wb_sel_out), 16'(wb_sel_in));
            chk("rnd.s.alu", alu_res_out, alu_res_in);
            chk("rnd.s.rdata", mem_rdata_out, dmem_rdata);
            chk("rnd.s.pc2", pc2_out, pc2_in);
            chk("rnd.s.imm", imm_eff_out, imm_eff_in);
          end
          @(posedge clk); #1;
          if (!pend) done = 1;
        end
        chk("rnd.s.finished", 16'(done), 16'd1);
      end else begin
        int q[$];
        int k;
        int c;
        valid_in = 1; lm_in = (op == 4); sm_in = (op == 5);
        mask_in = 8'($urandom);
        for (int i = 0; i < 8; i++) if (mask_in[i]) q.push_back(i);
        k = 0;
        c = 0;
        if (q.size() == 0) begin
          hcyc("rnd.nop", 0, 0, 0, 0, 0, '0, '0, '0, '0, '0);
        end
        while (q.size() > 0 && c < 80) begin
          logic [15:0] ea;
          dmem_ready = (c >= 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
          dmem_rdata = 16'($urandom);
          ea = alu_res_in + 16'(2 * k);
          @(negedge clk);
          chk("rnd.m.re", 16'(dmem_re), 16'(lm_in));
          chk("rnd.m.we", 16'(dmem_we), 16'(sm_in));
          chk("rnd.m.addr", dmem_addr, ea);
          chk("rnd.m.raddr", 16'(sm_raddr), 16'(q[0]));
          chk("rnd.m.stall", 16'(mem_stall), 16'(!dmem_ready || q.size() > 1));
          chk("rnd.m.rf_we", 16'(rf_we_out), 16'(dmem_ready && lm_in));
          if (sm_in) chk("rnd.m.wdata", dmem_wdata, rf[q[0]]);
          if (dmem_ready && lm_in) begin
            chk("rnd.m.waddr", 16'(rf_waddr_out), 16'(q[0]));
            chk("rnd.m.wb_sel", 16'(wb_sel_out), 16'd1);
            chk("rnd.m.rdata", mem_rdata_out, dmem_rdata);
            chk("rnd.m.pc2", pc2_out, pc2_in);
            chk("rnd.m.imm", imm_eff_out, imm_eff_in);
          end
          @(posedge clk); #1;
          if (dmem_ready) begin
            void'(q.pop_front());
            k++;
          end
          c++;
        end
        chk("rnd.m.finished", 16'(q.size()), 16'd0);
      end
    end
    clear_inputs();
    hcyc("final.bubble", 0, 0, 0, 0, 0, '0, '0, '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
